// File: rtl/pg_sequencer.sv
// Power-good sequencer: debounces a synchronized PG and sequences EN1/EN2
// up and down, latching a fault when PG is lost while the rails are enabled.
module pg_sequencer #(
   parameter int DEB_CYCLES = 16,
   parameter int SEQ_DELAY  = 8,
   parameter int TMR_W      = 8
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       PG,
   input  logic       REQ,
   input  logic       CLR_FAULT,
   output logic       EN1,
   output logic       EN2,
   output logic       PG_OK,
   output logic       FAULT,
   output logic [7:0] FAULT_CNT,
   output logic [2:0] STATE
);

   typedef enum logic [2:0] {
      ST_OFF      = 3'd0,
      ST_DEBOUNCE = 3'd1,
      ST_RAMP     = 3'd2,
      ST_ON       = 3'd3,
      ST_SHDN     = 3'd4,
      ST_FAULT    = 3'd5
   } state_e;

   localparam logic [TMR_W-1:0] DEB_LAST = TMR_W'(DEB_CYCLES - 1);
   localparam logic [TMR_W-1:0] SEQ_LAST = TMR_W'(SEQ_DELAY - 1);

   state_e           state_q, state_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic             pg_meta_q, pg_meta_d;
   logic             pg_sync_q, pg_sync_d;
   logic             en1_q, en1_d;
   logic             en2_q, en2_d;
   logic             pg_ok_q, pg_ok_d;
   logic             fault_q, fault_d;
   logic [7:0]       fault_cnt_q, fault_cnt_d;

   // Next-state, timer, fault counter and registered-output decode.
   always_comb begin
      pg_meta_d   = PG;
      pg_sync_d   = pg_meta_q;
      state_d     = state_q;
      timer_d     = timer_q;
      fault_cnt_d = fault_cnt_q;

      unique case (state_q)
         ST_OFF: begin
            if (REQ && pg_sync_q) begin
               state_d = ST_DEBOUNCE;
               timer_d = '0;
            end
         end
         ST_DEBOUNCE: begin
            if (!REQ) begin
               state_d = ST_OFF;
               timer_d = '0;
            end else if (!pg_sync_q) begin
               timer_d = '0;
            end else if (timer_q == DEB_LAST) begin
               state_d = ST_RAMP;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         ST_RAMP: begin
            if (!pg_sync_q) begin
               state_d = ST_FAULT;
               timer_d = '0;
            end else if (!REQ) begin
               state_d = ST_SHDN;
               timer_d = '0;
            end else if (timer_q == SEQ_LAST) begin
               state_d = ST_ON;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         ST_ON: begin
            if (!pg_sync_q) begin
               state_d = ST_FAULT;
               timer_d = '0;
            end else if (!REQ) begin
               state_d = ST_SHDN;
               timer_d = '0;
            end
         end
         ST_SHDN: begin
            if (timer_q == SEQ_LAST) begin
               state_d = ST_OFF;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         ST_FAULT: begin
            if (CLR_FAULT && !REQ) begin
               state_d = ST_OFF;
               timer_d = '0;
            end
         end
         default: begin
            state_d = ST_OFF;
            timer_d = '0;
         end
      endcase

      if (state_d == ST_FAULT && state_q != ST_FAULT && fault_cnt_q != 8'd255) begin
         fault_cnt_d = fault_cnt_q + 8'd1;
      end

      en1_d   = (state_d == ST_RAMP) || (state_d == ST_ON) || (state_d == ST_SHDN);
      en2_d   = (state_d == ST_ON);
      pg_ok_d = (state_d == ST_ON);
      fault_d = (state_d == ST_FAULT);
   end

   // State, synchronizer and output registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= ST_OFF;
         timer_q     <= '0;
         pg_meta_q   <= 1'b0;
         pg_sync_q   <= 1'b0;
         en1_q       <= 1'b0;
         en2_q       <= 1'b0;
         pg_ok_q     <= 1'b0;
         fault_q     <= 1'b0;
         fault_cnt_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         pg_meta_q   <= pg_meta_d;
         pg_sync_q   <= pg_sync_d;
         en1_q       <= en1_d;
         en2_q       <= en2_d;
         pg_ok_q     <= pg_ok_d;
         fault_q     <= fault_d;
         fault_cnt_q <= fault_cnt_d;
      end
   end

   assign EN1       = en1_q;
   assign EN2       = en2_q;
   assign PG_OK     = pg_ok_q;
   assign FAULT     = fault_q;
   assign FAULT_CNT = fault_cnt_q;
   assign STATE     = state_q;

endmodule
